alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
Shares the single combinational ALU (add/sub/logic/shift, with isNotEqual/isLessThan/overflow flags) between two requesters, e.g. the execute stage and a branch/compare unit.
- Each requester uses a valid/ready request handshake and a valid/ready response handshake.
- Requests are granted round-robin; the granted operands are registered, driven to the ALU for one cycle, then the captured result is held until the owner accepts it.
- Sits between the requesters and the ALU instance; it owns the ALU's operand and control inputs.

Parameters:
WIDTH, 32, operand/result width
OPW, 5, ALU opcode width
SHW, 5, shift-amount width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid0  in  1  requester 0 has a request
req_ready0  out  1  request 0 accepted this cycle (when valid also high)
req_op0  in  OPW  ALU opcode, requester 0
req_shamt0  in  SHW  shift amount, requester 0
req_a0  in  WIDTH  operand A, requester 0
req_b0  in  WIDTH  operand B, requester 0
req_valid1, req_ready1, req_op1, req_shamt1, req_a1, req_b1: same meaning and widths, requester 1
resp_valid0  out  1  response for requester 0 is valid
resp_valid1  out  1  response for requester 1 is valid
resp_ready0  in  1  requester 0 accepts response
resp_ready1  in  1  requester 1 accepts response
resp_result  out  WIDTH  captured ALU result (shared bus)
resp_ne  out  1  captured isNotEqual
resp_lt  out  1  captured isLessThan
resp_ovf  out  1  captured overflow
alu_opA  out  WIDTH  to ALU data_operandA
alu_opB  out  WIDTH  to ALU data_operandB
alu_opcode  out  OPW  to ALU ctrl_ALUopcode
alu_shamt  out  SHW  to ALU ctrl_shiftamt
alu_result  in  WIDTH  from ALU data_result
alu_ne  in  1  from ALU isNotEqual
alu_lt  in  1  from ALU isLessThan
alu_ovf  in  1  from ALU overflow
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (synchronous, reset high at a rising edge):
  - state=IDLE, owner=0, last_grant=1, so requester 0 wins the first tie.
  - All outputs 0: ready, resp_valid, resp_*, alu_*, busy.
  - Reset overrides every other event, including reset mid-EXEC or mid-RESP; any pending response is discarded and no handshake completes in that cycle.
- States: IDLE -> EXEC -> RESP -> IDLE. Two-bit encoding; the unused encoding returns to IDLE.
- IDLE, grant decision (combinational on the current valids and last_grant):
  - Only one valid: grant that requester.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant.
  - req_readyN=1 only for the granted requester, and only in IDLE; both readys are 0 in EXEC/RESP.
- IDLE, request accept: on clock edge with req_validN & req_readyN:
  - Register op/shamt/a/b of N into the alu_* output registers.
  - owner<=N, last_grant<=N, state<=EXEC.
- EXEC: alu_* hold the registered values for this whole cycle. At the clock edge, capture alu_result/ne/lt/ovf into resp_* and go to RESP.
- RESP:
  - resp_valid[owner]=1; the other resp_valid is 0.
  - resp_* stable until accepted.
  - On edge with resp_ready[owner]=1: state<=IDLE, resp_valid drops next cycle. The other requester's resp_ready is ignored.
- Latency and throughput:
  - Request accepted at edge N; resp_valid high in the cycle after edge N+1.
  - With resp_ready held high, the earliest next accept is the cycle after the response handshake, i.e. at most 1 op per 3 cycles.
- alu_* and resp_* retain their last values outside EXEC/RESP; they are not cleared except by reset.
- Requester rule: valid and payload must stay stable until ready. The arbiter re-evaluates the grant every IDLE cycle, so a withdrawn valid simply loses the grant.
- Stall behaviour: backpressure on the response (resp_ready low) stalls indefinitely. No new request is accepted, and busy stays 1.
- Widths: no arithmetic inside the block; fields pass through unmodified. Flags are meaningful per ALU convention (ne/lt after SUB opcode 00001).

Test Plan:
1. Reset: hold reset 2 cycles with both valids high -> all outputs 0, req_ready0/1=0 during reset. First IDLE cycle after release -> req_ready0=1, req_ready1=0.
2. Single request: r0 op=00000 A=5 B=7 -> accepted at edge N, alu_opA=5/alu_opB=7 during EXEC, resp_valid0=1 in the cycle after edge N+1 with result=12, resp_valid1=0, busy=1 throughout.
3. Tie and alternation: both requesters continuously valid, resp_ready tied high. r0 has SUB 9-9, r1 has SUB 3-8 -> grant order r0, r1, r0, r1. r0 response result=0, ne=0, lt=0. r1 response result=0xFFFFFFFB, ne=1, lt=1.
4. Backpressure: resp_ready0=0 for 5 cycles in RESP, with r1 valid -> resp_valid0 and resp_result stable, req_ready1=0 all 5 cycles. After resp_ready0=1, r1 is granted on the next IDLE cycle.
5. Overflow: SUB A=0x7FFFFFFF B=0xFFFFFFFF -> resp_result=0x80000000, resp_ovf=1.
6. Reset mid-operation: assert reset in EXEC, then in a separate run in RESP -> next cycle state IDLE, resp_valid0/1=0, resp_*=0, and no response is ever delivered for that request.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered for one EXEC cycle; the result is held in RESP until the owner accepts it.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid0,
  output logic             req_ready0,
  input  logic [OPW-1:0]   req_op0,
  input  logic [SHW-1:0]   req_shamt0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic             req_valid1,
  output logic             req_ready1,
  input  logic [OPW-1:0]   req_op1,
  input  logic [SHW-1:0]   req_shamt1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             resp_valid0,
  output logic             resp_valid1,
  input  logic             resp_ready0,
  input  logic             resp_ready1,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_ne,
  output logic             resp_lt,
  output logic             resp_ovf,
  output logic [WIDTH-1:0] alu_opA,
  output logic [WIDTH-1:0] alu_opB,
  output logic [OPW-1:0]   alu_opcode,
  output logic [SHW-1:0]   alu_shamt,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ne,
  input  logic             alu_lt,
  input  logic             alu_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t state, state_next;
  logic   owner, last_grant;
  logic   grant_any, grant_id;
  logic   resp_fire;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Handshake outputs are forced low while reset is asserted so nothing completes in a reset cycle.
  always_comb begin
    state_next  = state;
    grant_any   = 1'b0;
    grant_id    = 1'b0;
    resp_fire   = 1'b0;
    req_ready0  = 1'b0;
    req_ready1  = 1'b0;
    resp_valid0 = 1'b0;
    resp_valid1 = 1'b0;
    busy        = 1'b0;
    if (!reset) begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          if (req_valid0 && req_valid1) begin
            grant_any = 1'b1;
            grant_id  = ~last_grant;
          end else if (req_valid0) begin
            grant_any = 1'b1;
            grant_id  = 1'b0;
          end else if (req_valid1) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
          end
          req_ready0 = grant_any & ~grant_id;
          req_ready1 = grant_any & grant_id;
          if (grant_any) state_next = EXEC;
        end
        EXEC: state_next = RESP;
        RESP: begin
          resp_valid0 = ~owner;
          resp_valid1 = owner;
          resp_fire   = owner ? resp_ready1 : resp_ready0;
          if (resp_fire) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath registers keep their last values outside EXEC/RESP; only reset clears them.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      alu_opA     <= '0;
      alu_opB     <= '0;
      alu_opcode  <= '0;
      alu_shamt   <= '0;
      resp_result <= '0;
      resp_ne     <= 1'b0;
      resp_lt     <= 1'b0;
      resp_ovf    <= 1'b0;
    end else begin
      if (grant_any) begin
        owner      <= grant_id;
        last_grant <= grant_id;
        alu_opA    <= grant_id ? req_a1     : req_a0;
        alu_opB    <= grant_id ? req_b1     : req_b0;
        alu_opcode <= grant_id ? req_op1    : req_op0;
        alu_shamt  <= grant_id ? req_shamt1 : req_shamt0;
      end
      if (state == EXEC) begin
        resp_result <= alu_result;
        resp_ne     <= alu_ne;
        resp_lt     <= alu_lt;
        resp_ovf    <= alu_ovf;
      end
    end
  end

endmodule
